// File: rtl/lutram_pkg.sv
// Shared sizing constants and types for the 16-entry distributed-RAM FIFO.
package lutram_pkg;
  localparam int LUTRAM_DEPTH = 16;
  localparam int LUTRAM_AW    = 4;
  localparam int CNT_W        = 5;

  typedef logic [LUTRAM_AW-1:0] ptr_t;
  typedef logic [CNT_W-1:0]     cnt_t;
endpackage

// File: rtl/lutram_fifo_mem.sv
// Storage array: one 16x1 dual-port distributed RAM (RAM16X1D shape) per data bit.
module lutram_fifo_mem
  import lutram_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             WCLK,
  input  logic             we,
  input  ptr_t             a,
  input  logic [WIDTH-1:0] d,
  input  ptr_t             dpra,
  output logic [WIDTH-1:0] dpo
);

  // Synchronous write on A, asynchronous read on DPRA; SPO is not needed.
  for (genvar b = 0; b < WIDTH; b++) begin : g_ram16x1d
    logic [LUTRAM_DEPTH-1:0] cells;

    always_ff @(posedge WCLK) begin
      if (we) cells[a] <= d[b];
    end

    assign dpo[b] = cells[dpra];
  end

endmodule

// File: rtl/lutram_fifo.sv
// 16-entry FIFO with a first-word-fall-through output register in front of the RAM read port.
module lutram_fifo
  import lutram_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             WCLK,
  input  logic             CLR,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic [4:0]       level,
  output logic             overflow,
  output logic             underflow
);

  ptr_t             wr_ptr;
  ptr_t             rd_ptr;
  cnt_t             ram_cnt;
  logic [WIDTH-1:0] dpo;
  logic             wr_acc;
  logic             pop;
  logic             load;

  assign full   = (ram_cnt == cnt_t'(LUTRAM_DEPTH));
  assign level  = ram_cnt + cnt_t'(rd_valid);
  assign wr_acc = wr_en & ~full & ~flush;
  assign pop    = rd_en & rd_valid;
  // Refill the output register whenever it is empty or being consumed this cycle.
  assign load   = (~rd_valid | pop) & (ram_cnt != '0) & ~flush;

  lutram_fifo_mem #(
    .WIDTH (WIDTH)
  ) u_mem (
    .WCLK (WCLK),
    .we   (wr_acc),
    .a    (wr_ptr),
    .d    (wr_data),
    .dpra (rd_ptr),
    .dpo  (dpo)
  );

  always_ff @(posedge WCLK or posedge CLR) begin
    if (CLR) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ram_cnt   <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ram_cnt   <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ptr_t'(1);

      if (load) begin
        rd_data  <= dpo;
        rd_valid <= 1'b1;
        rd_ptr   <= rd_ptr + ptr_t'(1);
      end else if (pop) begin
        rd_valid <= 1'b0;
      end

      ram_cnt <= ram_cnt + cnt_t'(wr_acc) - cnt_t'(load);

      if (wr_en & full)      overflow  <= 1'b1;
      if (rd_en & ~rd_valid) underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lutram_fifo.sv
// Scenario bench for lutram_fifo against a queue-based reference model.
module tb_lutram_fifo;

  logic       WCLK = 1'b0;
  logic       CLR  = 1'b1;
  logic       flush = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = '0;
  logic       full;
  logic       rd_en = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [4:0] level;
  logic       overflow;
  logic       underflow;

  lutram_fifo #(.WIDTH(8)) dut (
    .WCLK      (WCLK),
    .CLR       (CLR),
    .flush     (flush),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .full      (full),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .level     (level),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 WCLK = ~WCLK;

  // Reference model: words in RAM as a queue plus the output register.
  logic [7:0] ramq[$];
  bit         mv;
  logic [7:0] md;
  bit         ovf, udf;
  int         nerr = 0;
  int         nchk = 0;

  logic [16:0] obs;
  assign obs = {rd_valid, rd_data, level, full, overflow, underflow};

  function automatic logic [16:0] exp_vec();
    int lvl;
    lvl = ramq.size() + (mv ? 1 : 0);
    return {mv, md, 5'(lvl), (ramq.size() == 16), ovf, udf};
  endfunction

  function automatic void model_clear();
    ramq.delete();
    mv  = 1'b0;
    md  = '0;
    ovf = 1'b0;
    udf = 1'b0;
  endfunction

  task automatic step(input bit w, input logic [7:0] wd, input bit r, input bit f);
    bit full_m, acc, popm, ld;
    wr_en = w; wr_data = wd; rd_en = r; flush = f;
    @(posedge WCLK);
    if (f) begin
      model_clear();
    end else begin
      full_m = (ramq.size() == 16);
      acc    = w && !full_m;
      popm   = r && mv;
      if (w && full_m) ovf = 1'b1;
      if (r && !mv)    udf = 1'b1;
      ld = (!mv || popm) && (ramq.size() > 0);
      if (ld) begin
        md = ramq.pop_front();
        mv = 1'b1;
      end else if (popm) begin
        mv = 1'b0;
      end
      if (acc) ramq.push_back(wd);
    end
    #1;
    wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset();
    model_clear();
    wr_en = 1'b1; wr_data = 8'h3C;
    for (int i = 0; i < 3; i++) begin
      @(posedge WCLK); #1;
      nchk++;
      if (obs !== 17'h0) begin
        nerr++;
        $display("FAIL reset_hold: got %h expected %h", obs, 17'h0);
      end
    end
    wr_en = 1'b0;
    @(negedge WCLK);
    CLR = 1'b0;
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    nchk++;
    if (obs !== exp_vec() || rd_valid !== 1'b0) begin
      nerr++;
      $display("FAIL first_write: got %h expected %h", obs, exp_vec());
    end
    step(1'b0, 8'h00, 1'b0, 1'b0);
    nchk++;
    if (rd_valid !== 1'b1 || rd_data !== 8'hA5 || level !== 5'd1) begin
      nerr++;
      $display("FAIL first_valid: got v=%b d=%h l=%0d expected v=1 d=a5 l=1", rd_valid, rd_data, level);
    end
  endtask

  task automatic test_fill_overflow();
    int e;
    step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 17; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0);
      nchk++;
      if (obs !== exp_vec()) begin
        nerr++;
        $display("FAIL fill_%0d: got %h expected %h", i, obs, exp_vec());
      end
    end
    nchk++;
    if (full !== 1'b1 || level !== 5'd17 || rd_valid !== 1'b1) begin
      nerr++;
      $display("FAIL full_flag: got full=%b level=%0d expected full=1 level=17", full, level);
    end
    step(1'b1, 8'hFF, 1'b0, 1'b0);
    nchk++;
    if (overflow !== 1'b1 || level !== 5'd17) begin
      nerr++;
      $display("FAIL overflow: got ovf=%b level=%0d expected ovf=1 level=17", overflow, level);
    end
    e = 0;
    for (int i = 0; i < 20; i++) begin
      if (rd_valid === 1'b1) begin
        nchk++;
        if (rd_data !== 8'(e)) begin
          nerr++;
          $display("FAIL drain_%0d: got %h expected %h", e, rd_data, 8'(e));
        end
        e++;
      end
      step(1'b0, 8'h00, 1'b1, 1'b0);
      nchk++;
      if (obs !== exp_vec()) begin
        nerr++;
        $display("FAIL drain_model_%0d: got %h expected %h", i, obs, exp_vec());
      end
    end
    nchk++;
    if (e != 17) begin
      nerr++;
      $display("FAIL drain_count: got %0d expected 17", e);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] prev;
    step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      prev = rd_data;
      step(1'b1, 8'(3 + i), 1'b1, 1'b0);
      nchk++;
      if (obs !== exp_vec() || level !== 5'd3 || rd_data !== prev + 8'd1) begin
        nerr++;
        $display("FAIL wrap_%0d: got %h (prev %h) expected %h", i, obs, prev, exp_vec());
      end
    end
  endtask

  task automatic test_underflow();
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    nchk++;
    if (underflow !== 1'b1 || level !== 5'd0 || rd_valid !== 1'b0 || obs !== exp_vec()) begin
      nerr++;
      $display("FAIL underflow: got %h expected %h", obs, exp_vec());
    end
    step(1'b0, 8'h00, 1'b0, 1'b1);
    nchk++;
    if (underflow !== 1'b0) begin
      nerr++;
      $display("FAIL underflow_clear: got %b expected 0", underflow);
    end
  endtask

  task automatic test_flush_priority();
    step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    nchk++;
    if (level !== 5'd5) begin
      nerr++;
      $display("FAIL flush_prefill: got level=%0d expected 5", level);
    end
    step(1'b1, 8'h77, 1'b1, 1'b1);
    nchk++;
    if (obs !== 17'h0) begin
      nerr++;
      $display("FAIL flush_priority: got %h expected %h", obs, 17'h0);
    end
    step(1'b1, 8'h11, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    nchk++;
    if (rd_valid !== 1'b1 || rd_data !== 8'h11 || level !== 5'd1) begin
      nerr++;
      $display("FAIL flush_after: got v=%b d=%h l=%0d expected v=1 d=11 l=1", rd_valid, rd_data, level);
    end
  endtask

  task automatic test_async_reset();
    step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    #2;
    CLR = 1'b1;
    model_clear();
    #1;
    nchk++;
    if (obs !== 17'h0) begin
      nerr++;
      $display("FAIL async_clr: got %h expected %h", obs, 17'h0);
    end
    CLR = 1'b0;
    step(1'b1, 8'h5A, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    nchk++;
    if (obs !== exp_vec() || rd_data !== 8'h5A) begin
      nerr++;
      $display("FAIL async_resume: got %h expected %h", obs, exp_vec());
    end
  endtask

  task automatic test_random();
    step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 3) != 0, 8'($urandom), ($urandom % 2) == 1, ($urandom % 60) == 0);
      nchk++;
      if (obs !== exp_vec()) begin
        nerr++;
        $display("FAIL random_%0d: got %h expected %h", i, obs, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_overflow();
    test_wrap();
    test_underflow();
    test_flush_priority();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/lutram_fifo.md
Name: lutram_fifo

Overview:
- Synchronous 16-entry FIFO storing data in RAM16X1D distributed-RAM primitives, one primitive per data bit.
- The write side drives the primitive's single-port address, D and WE.
- This block owns the read end: the DPRA address, the DPO data and a first-word-fall-through (FWFT) output register.
- Used as a small elastic buffer between bus-facing logic and slower peripherals in the Spartan-XL design.

Parameters:
- WIDTH, 8, data width in bits; one RAM16X1D per bit.

Ports:
- WCLK  in  1  clock; also the RAM write clock.
- CLR  in  1  asynchronous reset, active-high.
- flush  in  1  synchronous empty request; RAM contents are not touched.
- wr_en  in  1  write request.
- wr_data  in  WIDTH  write data.
- full  out  1  RAM holds 16 entries; a write this cycle is dropped.
- rd_en  in  1  pop the current output word.
- rd_data  out  WIDTH  FWFT output register.
- rd_valid  out  1  rd_data holds a valid word.
- level  out  5  entries held: RAM count plus rd_valid, range 0..17.
- overflow  out  1  sticky; a write was attempted while full.
- underflow  out  1  sticky; a read was attempted while rd_valid=0.

Behaviour:
- Reset:
  - CLR=1 asynchronously zeroes wr_ptr[3:0], rd_ptr[3:0], ram_cnt[4:0], rd_data, rd_valid, overflow and underflow.
  - Resulting outputs: full=0, level=0.
  - RAM contents are not reset.
  - CLR mid-operation discards all queued data. The first write after CLR releases behaves exactly as on an empty FIFO.
- Write acceptance:
  - A write is accepted when wr_en=1, full=0 and flush=0.
  - RAM WE=1, address wr_ptr. Data is stored on the WCLK rising edge.
  - wr_ptr increments modulo 16 (15 wraps to 0).
- Full and overflow:
  - full = (ram_cnt==16), computed combinationally from registered state.
  - A write while full is dropped, sets overflow, and leaves pointers and counts unchanged.
  - A simultaneous pop does not free space for a write in the same cycle.
- Pop and underflow:
  - A pop occurs when rd_en=1 and rd_valid=1.
  - rd_en=1 with rd_valid=0 sets underflow and has no other effect.
- Output register load:
  - Condition: (rd_valid=0 or pop) and ram_cnt>0 and flush=0.
  - Action: rd_data <= DPO word at rd_ptr, rd_valid <= 1, rd_ptr increments modulo 16, ram_cnt decrements.
  - If pop=1 and ram_cnt=0, then rd_valid <= 0 and rd_data holds its last value.
- RAM count update:
  - ram_cnt next = ram_cnt + accepted_write - load.
  - Write and load in the same cycle leave ram_cnt unchanged.
  - Arithmetic is 5-bit unsigned; the count never exceeds 16 and never goes below 0.
- Latency:
  - A write accepted at edge N into an empty FIFO raises rd_valid after edge N+1 (2-cycle write-to-valid).
  - There is no RAM bypass path.
  - Back-to-back pops sustain 1 word per cycle while ram_cnt>0.
- Read/write collision:
  - The read address equals the write address only when ram_cnt is 0 or 16.
  - No load happens at 0 and no write happens at 16, so read-during-write never occurs.
- Flush:
  - Same effect as CLR but synchronous, and it also clears overflow and underflow.
  - Flush wins over wr_en and rd_en in the same cycle.
  - A flush cycle sets neither sticky flag.
- level: ram_cnt + rd_valid, registered-state derived, combinational out.

Decomposition:
- Shared package lutram_pkg:
  - LUTRAM_DEPTH=16.
  - LUTRAM_AW=4.
  - Counter width constant CNT_W=5.
- Sub-module lutram_fifo_mem:
  - Generate loop of WIDTH RAM16X1D instances.
  - Address A = wr_ptr, DPRA = rd_ptr, common WE.
  - Outputs a WIDTH-bit DPO bus; SPO is unused.
- Top-level lutram_fifo: pointers, counters, FWFT register, flags.

Test Plan:
1. Reset and first word: hold CLR, release, then write 0xA5 at edge 0 -> rd_valid=1, rd_data=0xA5, level=1 after edge 1; level=0 throughout reset.
2. Fill and overflow: write 0x00..0x10 with rd_en=0 (17 words) -> full=1 after the 17th accepted write (ram_cnt=16, rd_valid=1), level=17. An 18th write of 0xFF sets overflow=1. Draining yields 0x00..0x10 in order, never 0xFF.
3. Wrap-around: 40 cycles of simultaneous write and pop of an incrementing pattern at steady state -> output strictly increments, level constant, pointers wrap 15->0 with no lost or duplicate word.
4. Underflow: rd_en=1 on an empty FIFO -> underflow=1, level stays 0, rd_valid stays 0. A following flush clears underflow.
5. Flush priority: with 5 words queued, assert flush together with wr_en=1 (data 0x77) and rd_en=1 -> next cycle level=0, rd_valid=0, full=0, no flags set. A subsequent write of 0x11 is read back as 0x11, not 0x77.
6. Async reset mid-stream: pulse CLR between clock edges while 8 words are queued -> all outputs are 0 immediately, without waiting for an edge. Normal operation resumes on the next write.
